// File: rtl/net_bus_frame_buffer.sv
// Store-and-forward NetBus frame FIFO: only complete frames reach the egress, oversize frames are dropped whole.
// Optional saturating frame statistics are built when NETBUS_FRM_STATS_EN is defined.
module net_bus_frame_buffer #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_FLITS  = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_WIDTH*9+13:0] WDATA,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [DATA_WIDTH*9+13:0] RDATA,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [ADDR_WIDTH:0]      FRAME_CNT,
    output logic                     DROP_PULSE,
    output logic [15:0]              STAT_ACCEPT,
    output logic [15:0]              STAT_DROP
);

    localparam int W  = DATA_WIDTH * 9 + 14;
    localparam int D  = 2 ** ADDR_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] DEPTH_P = PW'(D);
    localparam logic [PW-1:0] MAX_P   = PW'(MAX_FLITS);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [PW-1:0] ZERO_P  = PW'(0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [W-1:0]  mem_r [D];
    logic [PW-1:0] wr_ptr_r, cm_ptr_r, rd_ptr_r, flit_cnt_r, frame_cnt_r;
    logic [1:0]    state_r;
    logic          drop_pulse_r;

    logic [PW-1:0] wr_ptr_nxt_s, cm_ptr_nxt_s, flit_cnt_nxt_s;
    logic [1:0]    state_nxt_s;
    logic          full_s, pending_s, wready_s, wr_fire_s, rd_fire_s;
    logic          write_en_s, commit_s, drop_s;
    logic [W-1:0]  rdata_s;

    assign full_s    = (wr_ptr_r - rd_ptr_r) == DEPTH_P;
    assign pending_s = rd_ptr_r != cm_ptr_r;
    assign rdata_s   = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
    assign wr_fire_s = WVALID & wready_s;
    assign rd_fire_s = pending_s & RREADY;

    // Ingress ready: stall only when the ring is full and committed flits can still drain
    always_comb begin
        wready_s = 1'b0;
        if (RESET) begin
            wready_s = 1'b0;
        end else if (state_r == ST_DROP) begin
            wready_s = 1'b1;
        end else begin
            wready_s = !(full_s && pending_s);
        end
    end

    // Frame assembly FSM; a flit that would exceed the frame limit or overflow the ring discards the frame
    always_comb begin
        wr_ptr_nxt_s   = wr_ptr_r;
        cm_ptr_nxt_s   = cm_ptr_r;
        flit_cnt_nxt_s = flit_cnt_r;
        state_nxt_s    = state_r;
        write_en_s     = 1'b0;
        commit_s       = 1'b0;
        drop_s         = 1'b0;
        case (state_r)
            ST_DROP: begin
                if (wr_fire_s && WDATA[0]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            ST_IDLE, ST_RECV: begin
                if (!wr_fire_s) begin
                    state_nxt_s = state_r;
                end else if (flit_cnt_r == MAX_P || full_s) begin
                    drop_s         = 1'b1;
                    wr_ptr_nxt_s   = cm_ptr_r;
                    flit_cnt_nxt_s = ZERO_P;
                    state_nxt_s    = WDATA[0] ? ST_IDLE : ST_DROP;
                end else if (WDATA[0]) begin
                    write_en_s     = 1'b1;
                    commit_s       = 1'b1;
                    wr_ptr_nxt_s   = wr_ptr_r + ONE_P;
                    cm_ptr_nxt_s   = wr_ptr_r + ONE_P;
                    flit_cnt_nxt_s = ZERO_P;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    write_en_s     = 1'b1;
                    wr_ptr_nxt_s   = wr_ptr_r + ONE_P;
                    flit_cnt_nxt_s = flit_cnt_r + ONE_P;
                    state_nxt_s    = ST_RECV;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pointer, state and frame-count registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_r     <= ZERO_P;
            cm_ptr_r     <= ZERO_P;
            rd_ptr_r     <= ZERO_P;
            flit_cnt_r   <= ZERO_P;
            frame_cnt_r  <= ZERO_P;
            state_r      <= ST_IDLE;
            drop_pulse_r <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            cm_ptr_r     <= cm_ptr_nxt_s;
            flit_cnt_r   <= flit_cnt_nxt_s;
            state_r      <= state_nxt_s;
            drop_pulse_r <= drop_s;
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_P;
            end
            case ({commit_s, rd_fire_s & rdata_s[0]})
                2'b10:   frame_cnt_r <= frame_cnt_r + ONE_P;
                2'b01:   frame_cnt_r <= frame_cnt_r - ONE_P;
                default: frame_cnt_r <= frame_cnt_r;
            endcase
        end
    end

    // Flit storage, intentionally not reset
    always_ff @(posedge CLK) begin
        if (write_en_s) begin
            mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= WDATA;
        end
    end

    assign WREADY     = wready_s;
    assign RVALID     = pending_s;
    assign RDATA      = rdata_s;
    assign FRAME_CNT  = frame_cnt_r;
    assign DROP_PULSE = drop_pulse_r;

`ifdef NETBUS_FRM_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    logic [15:0] stat_accept_r, stat_drop_r;

    // Commit and drop counters, sticky at all-ones
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_accept_r <= 16'h0000;
            stat_drop_r   <= 16'h0000;
        end else begin
            if (commit_s) begin
                stat_accept_r <= sat_inc16(stat_accept_r);
            end
            if (drop_s) begin
                stat_drop_r <= sat_inc16(stat_drop_r);
            end
        end
    end

    assign STAT_ACCEPT = stat_accept_r;
    assign STAT_DROP   = stat_drop_r;
`else
    assign STAT_ACCEPT = 16'h0000;
    assign STAT_DROP   = 16'h0000;
`endif

endmodule
